// File: rtl/mem_client_port_if.sv
// Handshake and bus signals between a client core, mem_client_port and one arbiter port.
// The slave view belongs to mem_client_port; the master view to whatever drives it.
interface mem_client_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [14:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_enable;
    logic        mem_readWrite;
    logic [14:0] mem_address;
    logic [31:0] mem_data;
    logic [31:0] mem_rdata;
    logic        mem_done;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready, mem_rdata, mem_done,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_enable, mem_readWrite, mem_address, mem_data
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready, mem_rdata, mem_done,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_enable, mem_readWrite, mem_address, mem_data
    );
endinterface

// File: rtl/mem_client_port.sv
// Per-client front-end for one SRAM arbiter port: FIFO-buffers word requests, issues one
// at a time, waits for done (with a watchdog) and returns data/status on a response channel.
module mem_client_port #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input logic              clock,
    input logic              reset,
    mem_client_port_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP, ST_DRAIN} state_t;

    typedef struct packed {
        logic        write;
        logic [14:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t      state_q, state_d;
    req_t        fifo_q [DEPTH];
    req_t        fifo_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic [15:0] wdog_q, wdog_d;
    logic        mem_enable_q, mem_enable_d;
    logic        mem_readWrite_q, mem_readWrite_d;
    logic [14:0] mem_address_q, mem_address_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        push;
    logic        pop;
    req_t        head;

    assign push = bus.req_valid && req_ready_q;
    assign head = fifo_q[rd_ptr_q];

    always_comb begin
        state_d         = state_q;
        fifo_d          = fifo_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        cnt_d           = cnt_q;
        wdog_d          = wdog_q;
        mem_enable_d    = mem_enable_q;
        mem_readWrite_d = mem_readWrite_q;
        mem_address_d   = mem_address_q;
        mem_data_d      = mem_data_q;
        resp_valid_d    = resp_valid_q;
        resp_rdata_d    = resp_rdata_q;
        resp_err_d      = resp_err_q;
        pop             = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cnt_q != '0) begin
                    pop             = 1'b1;
                    mem_address_d   = head.addr;
                    mem_data_d      = head.write ? head.wdata : '0;
                    mem_readWrite_d = ~head.write;
                    state_d         = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_enable_d = 1'b1;
                wdog_d       = '0;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                // done is checked first so it wins when it lands on the timeout cycle
                if (bus.mem_done) begin
                    resp_rdata_d = mem_readWrite_q ? bus.mem_rdata : '0;
                    resp_err_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    mem_enable_d = 1'b0;
                    state_d      = ST_RESP;
                end else if (wdog_q == 16'(TIMEOUT)) begin
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    mem_enable_d = 1'b0;
                    state_d      = ST_RESP;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // arbiter done may linger; re-issuing under it would be taken as a second done
                if (!bus.mem_done) state_d = ST_IDLE;
            end
            default: begin
                mem_enable_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase

        if (push) begin
            fifo_d[wr_ptr_q] = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (!push && pop) cnt_d = cnt_q - CW'(1);
        req_ready_d = (cnt_d != CW'(DEPTH));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            fifo_q          <= '{default: '0};
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            cnt_q           <= '0;
            req_ready_q     <= 1'b0;
            wdog_q          <= '0;
            mem_enable_q    <= 1'b0;
            mem_readWrite_q <= 1'b1;
            mem_address_q   <= '0;
            mem_data_q      <= '0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
            resp_err_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            fifo_q          <= fifo_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            cnt_q           <= cnt_d;
            req_ready_q     <= req_ready_d;
            wdog_q          <= wdog_d;
            mem_enable_q    <= mem_enable_d;
            mem_readWrite_q <= mem_readWrite_d;
            mem_address_q   <= mem_address_d;
            mem_data_q      <= mem_data_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_err_q      <= resp_err_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.mem_enable    = mem_enable_q;
    assign bus.mem_readWrite = mem_readWrite_q;
    assign bus.mem_address   = mem_address_q;
    assign bus.mem_data      = mem_data_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.resp_err      = resp_err_q;
endmodule

// File: tb/tb_mem_client_port.sv
// Bench for mem_client_port: arbiter/client models on the falling edge, an in-order
// reference of expected issues and responses, directed table rows plus random traffic.
module tb_mem_client_port;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 10;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_client_port_if bus ();

    mem_client_port #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    typedef struct packed {
        logic        rw;
        logic [14:0] addr;
        logic [31:0] data;
    } iss_t;

    typedef struct {
        logic        w;
        logic [14:0] a;
        logic [31:0] d;
        int          delay;
        int          hold;
        logic        err;
        logic [31:0] rdata;
        int          en_len;
    } vec_t;

    int checks = 0;
    int errors = 0;

    resp_t       exp_resp_q[$];
    iss_t        exp_iss_q[$];
    logic [31:0] shadow  [int];
    logic [31:0] arb_mem [int];

    int    done_delay  = 3;
    int    done_hold   = 1;
    bit    rand_arb    = 1'b0;
    int    resp_prob   = 100;
    int    en_cnt      = 0;
    int    done_left   = 0;
    int    cur_delay   = 0;
    bit    armed       = 1'b1;
    int    last_en_len = 0;
    int    issues_seen = 0;
    int    resp_cnt    = 0;
    resp_t last_resp;
    iss_t  cur;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_shadow(input logic [14:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : 32'h0;
    endfunction

    // Reference: every accepted request is issued once, in order, and answered once, in order.
    function automatic void model_push(input logic w, input logic [14:0] a,
                                       input logic [31:0] d, input logic err);
        iss_t  i;
        resp_t r;
        i.rw    = ~w;
        i.addr  = a;
        i.data  = w ? d : 32'h0;
        r.err   = err;
        r.rdata = (err || w) ? 32'h0 : rd_shadow(a);
        exp_iss_q.push_back(i);
        exp_resp_q.push_back(r);
        if (w && !err) shadow[int'(a)] = d;
    endfunction

    // Arbiter port model, response sink and issue checker, all on the falling edge.
    initial begin
        iss_t  e_iss;
        resp_t e_resp;
        bus.mem_done   = 1'b0;
        bus.mem_rdata  = 32'h0;
        bus.resp_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                en_cnt = 0; done_left = 0; armed = 1'b1;
                bus.mem_done = 1'b0; bus.resp_ready = 1'b0;
                continue;
            end
            bus.resp_ready = (int'($urandom_range(99, 0)) < resp_prob);
            if (bus.resp_valid && bus.resp_ready) begin
                resp_cnt++;
                last_resp = {bus.resp_err, bus.resp_rdata};
                if (exp_resp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp got=%0h expected=none", last_resp);
                end else begin
                    e_resp = exp_resp_q.pop_front();
                    check("resp", 64'(last_resp), 64'(e_resp));
                end
            end
            if (bus.mem_enable) begin
                en_cnt++;
                if (en_cnt == 1) begin
                    issues_seen++;
                    check("done_low_at_issue", 64'(bus.mem_done), 64'(0));
                    cur = {bus.mem_readWrite, bus.mem_address, bus.mem_data};
                    if (exp_iss_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_issue got=%0h expected=none", cur);
                    end else begin
                        e_iss = exp_iss_q.pop_front();
                        check("issue_cmd", 64'(cur), 64'(e_iss));
                    end
                    cur_delay = rand_arb ? int'($urandom_range(6, 1)) : done_delay;
                end else begin
                    check("issue_stable", 64'({bus.mem_readWrite, bus.mem_address, bus.mem_data}), 64'(cur));
                end
                if (armed && cur_delay != 0 && en_cnt == cur_delay) begin
                    armed     = 1'b0;
                    done_left = rand_arb ? int'($urandom_range(3, 1)) : done_hold;
                    if (!cur.rw) arb_mem[int'(cur.addr)] = cur.data;
                    else bus.mem_rdata = arb_mem.exists(int'(cur.addr)) ? arb_mem[int'(cur.addr)] : 32'h0;
                end
            end else begin
                if (en_cnt != 0) last_en_len = en_cnt;
                en_cnt = 0;
                armed  = 1'b1;
            end
            bus.mem_done = (done_left > 0);
            if (done_left > 0) done_left--;
        end
    end

    // Called at a falling edge; returns at a falling edge with req_valid low.
    task automatic send(input logic w, input logic [14:0] a, input logic [31:0] d, input logic err);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (!bus.req_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!bus.req_ready) begin
            checks++; errors++;
            $display("FAIL req_accept_timeout got=ready0 expected=ready1 addr=%0h", a);
        end else begin
            model_push(w, a, d, err);
        end
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int target);
        int n = 0;
        while (resp_cnt < target && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (resp_cnt < target) begin
            checks++; errors++;
            $display("FAIL resp_timeout got=%0d expected=%0d", resp_cnt, target);
        end
    endtask

    vec_t tbl [11];
    int   n0;
    int   iss0;
    int   waitn;

    initial begin
        tbl[0]  = '{1'b1, 15'h0010, 32'hDEADBEEF, 3,  1, 1'b0, 32'h0,        3};
        tbl[1]  = '{1'b0, 15'h0010, 32'h0,        3,  1, 1'b0, 32'hDEADBEEF, 3};
        tbl[2]  = '{1'b1, 15'h0020, 32'h12345678, 3,  4, 1'b0, 32'h0,        3};
        tbl[3]  = '{1'b0, 15'h0020, 32'h0,        4,  4, 1'b0, 32'h12345678, 4};
        tbl[4]  = '{1'b0, 15'h0010, 32'h0,        0,  1, 1'b1, 32'h0,        11};
        tbl[5]  = '{1'b0, 15'h0010, 32'h0,        5,  1, 1'b0, 32'hDEADBEEF, 5};
        tbl[6]  = '{1'b0, 15'h0020, 32'h0,        11, 1, 1'b0, 32'h12345678, 11};
        tbl[7]  = '{1'b1, 15'h0030, 32'hCAFEF00D, 12, 1, 1'b1, 32'h0,        11};
        tbl[8]  = '{1'b0, 15'h0030, 32'h0,        2,  2, 1'b0, 32'h0,        2};
        tbl[9]  = '{1'b1, 15'h7FFF, 32'hFFFFFFFF, 1,  1, 1'b0, 32'h0,        1};
        tbl[10] = '{1'b0, 15'h7FFF, 32'h0,        1,  3, 1'b0, 32'hFFFFFFFF, 1};

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_mem_enable", 64'(bus.mem_enable), 64'(0));
        check("rst_mem_readWrite", 64'(bus.mem_readWrite), 64'(1));
        check("rst_mem_address", 64'(bus.mem_address), 64'(0));
        check("rst_mem_data", 64'(bus.mem_data), 64'(0));
        check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("rst_resp_rdata", 64'(bus.resp_rdata), 64'(0));
        check("rst_resp_err", 64'(bus.resp_err), 64'(0));
        check("rst_req_ready", 64'(bus.req_ready), 64'(0));
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("post_rst_req_ready", 64'(bus.req_ready), 64'(1));

        // Directed rows: write/read, long done, timeout, done-on-timeout, late done
        @(negedge clock);
        for (int i = 0; i < 11; i++) begin
            done_delay = tbl[i].delay;
            done_hold  = tbl[i].hold;
            n0 = resp_cnt;
            send(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].err);
            wait_resp(n0 + 1);
            check($sformatf("row%0d_err", i), 64'(last_resp.err), 64'(tbl[i].err));
            check($sformatf("row%0d_rdata", i), 64'(last_resp.rdata), 64'(tbl[i].rdata));
            check($sformatf("row%0d_en_len", i), 64'(last_en_len), 64'(tbl[i].en_len));
        end

        // Back-to-back: fill FIFO behind one stalled response, then drain in order
        done_delay = 3; done_hold = 1; resp_prob = 100;
        n0 = resp_cnt;
        for (int i = 0; i < 5; i++) send(1'b1, 15'(i), 32'hA5000000 + 32'(i * 17), 1'b0);
        wait_resp(n0 + 5);
        resp_prob = 0;
        n0 = resp_cnt;
        for (int i = 0; i < 5; i++) send(1'b0, 15'(i), 32'h0, 1'b0);
        repeat (4) @(negedge clock);
        check("b2b_req_ready_full", 64'(bus.req_ready), 64'(0));
        check("b2b_no_resp_while_stalled", 64'(resp_cnt), 64'(n0));
        resp_prob = 100;
        wait_resp(n0 + 5);
        check("b2b_all_issued", 64'(exp_iss_q.size()), 64'(0));

        // Random traffic against the reference
        rand_arb = 1'b1; resp_prob = 60;
        for (int i = 0; i < 40; i++) begin
            send(1'($urandom_range(1, 0)), 15'($urandom_range(7, 0)), $urandom, 1'b0);
            repeat ($urandom_range(2, 0)) @(negedge clock);
        end
        waitn = 0;
        while (exp_resp_q.size() != 0 && waitn < 3000) begin
            @(negedge clock);
            waitn++;
        end
        check("rand_drained", 64'(exp_resp_q.size()), 64'(0));
        rand_arb = 1'b0; resp_prob = 100;

        // Reset while WAITing with a second request still queued
        done_delay = 0;
        send(1'b0, 15'h0010, 32'h0, 1'b1);
        send(1'b0, 15'h0011, 32'h0, 1'b1);
        waitn = 0;
        while (!bus.mem_enable && waitn < 50) begin
            @(negedge clock);
            waitn++;
        end
        check("pre_reset_enable", 64'(bus.mem_enable), 64'(1));
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_resp_q.delete();
        exp_iss_q.delete();
        @(posedge clock);
        #1;
        check("mid_rst_mem_enable", 64'(bus.mem_enable), 64'(0));
        check("mid_rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("mid_rst_req_ready", 64'(bus.req_ready), 64'(0));
        n0 = resp_cnt;
        iss0 = issues_seen;
        reset = 1'b1;
        done_delay = 3;
        repeat (30) @(negedge clock);
        check("post_rst_no_resp", 64'(resp_cnt), 64'(n0));
        check("post_rst_no_issue", 64'(issues_seen), 64'(iss0));
        send(1'b0, 15'h0010, 32'h0, 1'b0);
        wait_resp(n0 + 1);
        check("post_rst_read_err", 64'(last_resp.err), 64'(0));
        check("post_rst_read_rdata", 64'(last_resp.rdata), 64'(32'hDEADBEEF));

        repeat (5) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end
endmodule
